// File: rtl/shared_mem_responder.sv
// Memory-side responder for the host/FPGA shared-memory protocol: owns the word store,
// orders host writes through a small queue, and passes start/status flag words both ways.
module shared_mem_responder #(
    parameter int          MEM_AW    = 18,
    parameter int          HWQ_DEPTH = 4,
    parameter logic [20:0] FLAG_ADDR = 21'h1F_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pci_input_data,
    input  logic [20:0] pci_req_addr,
    input  logic        pci_wr_en,
    input  logic        rd_req,
    input  logic [20:0] req_addr,
    input  logic        FPGA_wr_en,
    input  logic [31:0] write_data,
    input  logic        flag_we,
    input  logic [31:0] out_flag,
    output logic [31:0] rd_data,
    output logic        rd_ready,
    output logic [31:0] in_flag,
    output logic [31:0] host_flag,
    output logic        proto_err
);

    localparam int ADDR_W    = 21;
    localparam int PTR_W     = $clog2(HWQ_DEPTH);
    localparam int MEM_WORDS = 1 << MEM_AW;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(HWQ_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } hwq_entry_t;

    function automatic logic in_ram(input logic [ADDR_W-1:0] addr);
        return (addr >> MEM_AW) == '0;
    endfunction

    // Host write queue state
    hwq_entry_t       r_hwq [HWQ_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // Word store and read path
    logic [31:0]      r_ram [MEM_WORDS];
    logic [31:0]      r_ram_q;
    logic             r_rd_sel;
    logic             r_rd_ready;
    logic [31:0]      r_in_flag;
    logic [31:0]      r_host_flag;
    logic             r_proto_err;

    logic             w_hwq_empty;
    logic             w_hwq_full;
    logic             w_fpga_access;
    logic             w_push;
    logic             w_pop;
    logic             w_overflow;
    hwq_entry_t       w_head;
    logic             w_head_is_flag;
    logic             w_head_in_ram;
    logic             w_fpga_in_ram;
    logic             w_fpga_rd;
    logic             w_fpga_wr;
    logic             w_ram_we;
    logic             w_ram_re;
    logic [MEM_AW-1:0] w_ram_addr;
    logic [31:0]      w_ram_wdata;
    logic             w_err_set;

    assign w_hwq_empty   = (r_count == '0);
    assign w_hwq_full    = (r_count == FULL_COUNT);
    assign w_fpga_access = rd_req | FPGA_wr_en;

    // FPGA traffic owns the single RAM port; the queue drains only in idle cycles.
    assign w_pop      = !w_hwq_empty && !w_fpga_access;
    assign w_push     = pci_wr_en && (!w_hwq_full || w_pop);
    assign w_overflow = pci_wr_en && w_hwq_full && !w_pop;

    assign w_head         = r_hwq[r_rd_ptr];
    assign w_head_is_flag = (w_head.addr == FLAG_ADDR);
    assign w_head_in_ram  = in_ram(w_head.addr);

    assign w_fpga_in_ram = in_ram(req_addr);
    assign w_fpga_rd     = rd_req && !FPGA_wr_en;
    assign w_fpga_wr     = FPGA_wr_en && w_fpga_in_ram;

    assign w_ram_we    = w_fpga_access ? w_fpga_wr
                                       : (w_pop && !w_head_is_flag && w_head_in_ram);
    assign w_ram_re    = w_fpga_rd && w_fpga_in_ram;
    assign w_ram_addr  = w_fpga_access ? req_addr[MEM_AW-1:0] : w_head.addr[MEM_AW-1:0];
    assign w_ram_wdata = w_fpga_access ? write_data : w_head.data;

    assign w_err_set = w_overflow
                     | (w_pop && !w_head_is_flag && !w_head_in_ram)
                     | (FPGA_wr_en && !w_fpga_in_ram)
                     | (w_fpga_rd && !w_fpga_in_ram)
                     | (rd_req && FPGA_wr_en);

    // NOTE: storage arrays carry no reset; the occupancy count and r_rd_sel are what make them valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_hwq[r_wr_ptr] <= '{addr: pci_req_addr, data: pci_input_data};
        end
        if (w_ram_we) begin
            r_ram[w_ram_addr] <= w_ram_wdata;
        end
        if (w_ram_re) begin
            r_ram_q <= r_ram[w_ram_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_sel    <= 1'b0;
            r_rd_ready  <= 1'b0;
            r_in_flag   <= '0;
            r_host_flag <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_rd_ready <= w_fpga_rd;
            // Out-of-range reads return zero without touching the RAM output register.
            if (w_fpga_rd) begin
                r_rd_sel <= w_fpga_in_ram;
            end

            r_in_flag <= (w_pop && w_head_is_flag) ? w_head.data : '0;

            if (flag_we) begin
                r_host_flag <= out_flag;
            end
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign rd_data   = r_rd_sel ? r_ram_q : '0;
    assign rd_ready  = r_rd_ready;
    assign in_flag   = r_in_flag;
    assign host_flag = r_host_flag;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_shared_mem_responder.sv
// Scoreboard bench for shared_mem_responder: a queue-based reference model predicts read
// data, flag pulses and sticky status; a negedge monitor compares every cycle.
module tb_shared_mem_responder;

    localparam int          MEM_AW    = 18;
    localparam int          HWQ_DEPTH = 4;
    localparam logic [20:0] FLAG_ADDR = 21'h1F_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pci_input_data;
    logic [20:0] pci_req_addr;
    logic        pci_wr_en;
    logic        rd_req;
    logic [20:0] req_addr;
    logic        FPGA_wr_en;
    logic [31:0] write_data;
    logic        flag_we;
    logic [31:0] out_flag;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic [31:0] in_flag;
    logic [31:0] host_flag;
    logic        proto_err;

    always #5 clk = ~clk;

    shared_mem_responder #(
        .MEM_AW   (MEM_AW),
        .HWQ_DEPTH(HWQ_DEPTH),
        .FLAG_ADDR(FLAG_ADDR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pci_input_data(pci_input_data),
        .pci_req_addr  (pci_req_addr),
        .pci_wr_en     (pci_wr_en),
        .rd_req        (rd_req),
        .req_addr      (req_addr),
        .FPGA_wr_en    (FPGA_wr_en),
        .write_data    (write_data),
        .flag_we       (flag_we),
        .out_flag      (out_flag),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .in_flag       (in_flag),
        .host_flag     (host_flag),
        .proto_err     (proto_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [20:0] addr;
        logic [31:0] data;
    } hw_t;

    hw_t         m_hq[$];
    logic [31:0] m_mem[int];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_flag_q[$];
    logic [31:0] m_host_flag;
    logic        m_err;

    function automatic bit in_range(input logic [20:0] a);
        return int'(a) < (1 << MEM_AW);
    endfunction

    task automatic model_reset();
        m_hq.delete();
        exp_rd_q.delete();
        exp_flag_q.delete();
        m_host_flag = '0;
        m_err       = 1'b0;
    endtask

    // Applies the inputs sampled at the clock edge that just occurred.
    task automatic model_step();
        hw_t e;
        if (!(rd_req || FPGA_wr_en) && m_hq.size() > 0) begin
            e = m_hq.pop_front();
            if (e.addr == FLAG_ADDR)  exp_flag_q.push_back(e.data);
            else if (in_range(e.addr)) m_mem[int'(e.addr)] = e.data;
            else                      m_err = 1'b1;
        end
        if (pci_wr_en) begin
            if (m_hq.size() < HWQ_DEPTH) begin
                e.addr = pci_req_addr;
                e.data = pci_input_data;
                m_hq.push_back(e);
            end else begin
                m_err = 1'b1;
            end
        end
        if (FPGA_wr_en) begin
            if (in_range(req_addr)) m_mem[int'(req_addr)] = write_data;
            else                    m_err = 1'b1;
            if (rd_req) m_err = 1'b1;
        end else if (rd_req) begin
            if (in_range(req_addr)) begin
                exp_rd_q.push_back(m_mem[int'(req_addr)]);
            end else begin
                exp_rd_q.push_back(32'h0);
                m_err = 1'b1;
            end
        end
        if (flag_we) m_host_flag = out_flag;
    endtask

    // ---------------- monitor ----------------
    logic [31:0] last_rd = '0;
    logic [31:0] mon_exp;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            check("reset_rd_data", rd_data, 32'h0);
            check("reset_rd_ready", {31'h0, rd_ready}, 32'h0);
            check("reset_in_flag", in_flag, 32'h0);
            check("reset_host_flag", host_flag, 32'h0);
            check("reset_proto_err", {31'h0, proto_err}, 32'h0);
            last_rd = '0;
        end else begin
            if (exp_rd_q.size() > 0) begin
                mon_exp = exp_rd_q.pop_front();
                check("rd_ready", {31'h0, rd_ready}, 32'h1);
                check("rd_data", rd_data, mon_exp);
                last_rd = mon_exp;
            end else begin
                check("rd_ready_idle", {31'h0, rd_ready}, 32'h0);
                check("rd_data_hold", rd_data, last_rd);
            end
            if (exp_flag_q.size() > 0) begin
                mon_exp = exp_flag_q.pop_front();
                check("in_flag", in_flag, mon_exp);
            end else begin
                check("in_flag_idle", in_flag, 32'h0);
            end
            check("host_flag", host_flag, m_host_flag);
            check("proto_err", {31'h0, proto_err}, {31'h0, m_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        pci_input_data = '0;
        pci_req_addr   = '0;
        pci_wr_en      = 1'b0;
        rd_req         = 1'b0;
        req_addr       = '0;
        FPGA_wr_en     = 1'b0;
        write_data     = '0;
        flag_we        = 1'b0;
        out_flag       = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic host_write(input logic [20:0] a, input logic [31:0] d);
        set_idle();
        pci_wr_en = 1'b1; pci_req_addr = a; pci_input_data = d;
        cycle();
        set_idle();
    endtask

    task automatic fpga_write(input logic [20:0] a, input logic [31:0] d);
        set_idle();
        FPGA_wr_en = 1'b1; req_addr = a; write_data = d;
        cycle();
        set_idle();
    endtask

    task automatic fpga_read(input logic [20:0] a);
        set_idle();
        rd_req = 1'b1; req_addr = a;
        cycle();
        set_idle();
    endtask

    // Called just after an edge: reset lands mid-cycle, then is held two edges.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        set_idle();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        int r;
        pci_wr_en = ($urandom_range(0, 99) < 45);
        r = $urandom_range(0, 99);
        if (r < 80)      pci_req_addr = 21'($urandom_range(0, 15));
        else if (r < 90) pci_req_addr = FLAG_ADDR;
        else             pci_req_addr = 21'($urandom_range(32'h04_0000, 32'h1F_FFFE));
        pci_input_data = $urandom;
        rd_req     = ($urandom_range(0, 99) < 35);
        FPGA_wr_en = ($urandom_range(0, 99) < 12);
        req_addr   = ($urandom_range(0, 99) < 94) ? 21'($urandom_range(0, 15))
                                                  : 21'($urandom_range(32'h04_0000, 32'h1F_FFFF));
        write_data = $urandom;
        flag_we    = ($urandom_range(0, 99) < 10);
        out_flag   = $urandom;
    endtask

    // ---------------- test sequence ----------------
    int          flag_cnt;
    logic [31:0] flag_val;

    initial begin
        rst_n = 1'b1;
        set_idle();
        model_reset();
        #1 rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Host data writes followed by the start flag, no FPGA traffic.
        host_write(21'd0, 32'h0000_0042);
        host_write(21'd1, 32'hFFFF_0000);
        host_write(FLAG_ADDR, 32'h0001_0000);
        flag_cnt = 0;
        flag_val = '0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (in_flag != 32'h0) begin
                flag_cnt++;
                flag_val = in_flag;
            end
        end
        check("tp1_flag_value", flag_val, 32'h0001_0000);
        check("tp1_flag_cycles", flag_cnt, 32'd1);
        fpga_read(21'd0);
        check("tp1_rd0", rd_data, 32'h0000_0042);
        check("tp1_rdy0", {31'h0, rd_ready}, 32'h1);
        fpga_read(21'd1);
        check("tp1_rd1", rd_data, 32'hFFFF_0000);
        check("tp1_rdy1", {31'h0, rd_ready}, 32'h1);

        // Queue overflow while continuous FPGA reads stall the drain.
        fpga_write(21'd24, 32'hAAAA_0024);
        check("tp2_err_before", {31'h0, proto_err}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            set_idle();
            rd_req = 1'b1; req_addr = 21'd0;
            pci_wr_en = 1'b1; pci_req_addr = 21'(20 + i); pci_input_data = 32'hB000_0000 + 32'(i);
            cycle();
        end
        set_idle();
        check("tp2_err_overflow", {31'h0, proto_err}, 32'h1);
        idle_cycles(6);
        for (int i = 0; i < 4; i++) begin
            fpga_read(21'(20 + i));
            check("tp2_rd_queued", rd_data, 32'hB000_0000 + 32'(i));
        end
        fpga_read(21'd24);
        check("tp2_rd_dropped", rd_data, 32'hAAAA_0024);

        // Write then immediate read-back.
        fpga_write(21'd70, 32'h1111_0005);
        fpga_read(21'd70);
        check("tp3_rd_after_wr", rd_data, 32'h1111_0005);

        // Out-of-range read and read/write collision.
        pulse_reset();
        check("tp4_err_cleared", {31'h0, proto_err}, 32'h0);
        fpga_read(21'h04_0000);
        check("tp4_oor_data", rd_data, 32'h0);
        check("tp4_oor_rdy", {31'h0, rd_ready}, 32'h1);
        check("tp4_oor_err", {31'h0, proto_err}, 32'h1);
        set_idle();
        rd_req = 1'b1; FPGA_wr_en = 1'b1; req_addr = 21'd5; write_data = 32'h5555_0005;
        cycle();
        set_idle();
        check("tp4_collide_rdy", {31'h0, rd_ready}, 32'h0);
        fpga_read(21'd5);
        check("tp4_collide_wr", rd_data, 32'h5555_0005);

        // Status flag latch and hold.
        set_idle();
        flag_we = 1'b1; out_flag = 32'hDEAD_0001;
        cycle();
        set_idle();
        check("tp5_host_flag", host_flag, 32'hDEAD_0001);
        for (int i = 0; i < 3; i++) begin
            out_flag = $urandom;
            cycle();
            check("tp5_host_flag_hold", host_flag, 32'hDEAD_0001);
        end

        // Reset with three stalled queue entries, including a flag.
        fpga_write(21'd30, 32'h3030_0030);
        fpga_write(21'd31, 32'h3131_0031);
        for (int i = 0; i < 4; i++) begin
            set_idle();
            rd_req = 1'b1; req_addr = 21'd0;
            if (i < 3) begin
                pci_wr_en      = 1'b1;
                pci_req_addr   = (i == 2) ? FLAG_ADDR : 21'(30 + i);
                pci_input_data = (i == 2) ? 32'h0000_F1A6 : 32'hDEAD_0030 + 32'(i);
            end
            cycle();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("tp6_rst_rd_data", rd_data, 32'h0);
        check("tp6_rst_rd_ready", {31'h0, rd_ready}, 32'h0);
        check("tp6_rst_host_flag", host_flag, 32'h0);
        check("tp6_rst_proto_err", {31'h0, proto_err}, 32'h0);
        set_idle();
        cycle();
        cycle();
        rst_n = 1'b1;
        flag_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (in_flag != 32'h0) flag_cnt++;
        end
        check("tp6_no_flag", flag_cnt, 32'd0);
        fpga_read(21'd30);
        check("tp6_rd30", rd_data, 32'h3030_0030);
        fpga_read(21'd31);
        check("tp6_rd31", rd_data, 32'h3131_0031);

        // Randomized traffic over a small known address window.
        for (int a = 0; a < 16; a++) fpga_write(21'(a), $urandom);
        for (int blk = 0; blk < 10; blk++) begin
            for (int i = 0; i < 300; i++) begin
                rand_inputs();
                cycle();
            end
            pulse_reset();
        end
        idle_cycles(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
